// File: rtl/boreal_gate_pkg.sv
// Shared definitions for the Boreal action gate.
// Holds the gate FSM encoding, the request record carried through the FIFO,
// default rate-limit parameters and the register-index to byte-address helper.
package boreal_gate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WRITE = 2'd2
    } gate_state_t;

    localparam int IDX_SHIFT       = 2;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_RATE_WINDOW = 1024;
    localparam int DEF_RATE_MAX    = 16;

    // One queued action: register index plus the value to write (40 bits).
    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] data;
    } gate_req_t;

    localparam int REQ_W = $bits(gate_req_t);

    // Register index -> byte address; upper address bits are always zero.
    function automatic logic [31:0] idx_to_addr(input logic [7:0] idx);
        return 32'(idx) << IDX_SHIFT;
    endfunction

endpackage

// File: rtl/boreal_sync_fifo.sv
// Synchronous FIFO with combinational head (no read latency).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (pointers only)
//   push_i/wdata_i  write strobe and data; ignored while full
//   pop_i           advance the head; ignored while empty
//   rdata_o         current head entry, valid whenever empty_o is 0
//   full_o/empty_o  occupancy flags, derived from registered pointers only
module boreal_sync_fifo
    import boreal_gate_pkg::*;
#(
    parameter int WIDTH = REQ_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/boreal_action_gate.sv
// Boreal action gate: sole bus master writing the privileged I/O register bank.
// Queues (index, value) action requests, checks each one against the arm bit,
// the index limit and a per-window grant budget, and issues approved requests
// as single bus writes. Denied requests are dropped, pulsed and counted.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready = FIFO not full)
//   req_idx/req_data           target register index and value
//   cfg_arm, cfg_idx_limit     gate enable and exclusive index limit
//   m_sel/m_wr/m_addr/m_wdata  registered bus write toward the I/O bank
//   m_ack                      slave acknowledge, ends the write
//   deny_pulse, deny_count     one pulse per denial, saturating count
//   busy                       FIFO non-empty or FSM not idle
module boreal_action_gate
    import boreal_gate_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int RATE_WINDOW = DEF_RATE_WINDOW,
    parameter int RATE_MAX    = DEF_RATE_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_idx,
    input  logic [31:0] req_data,
    input  logic        cfg_arm,
    input  logic [7:0]  cfg_idx_limit,
    output logic        m_sel,
    output logic        m_wr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    output logic        deny_pulse,
    output logic [15:0] deny_count,
    output logic        busy
);

    localparam int         WIN_W    = $clog2(RATE_WINDOW);
    localparam logic [7:0] RMAX     = 8'(RATE_MAX);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(RATE_WINDOW - 1);

    gate_state_t      state_q, state_d;
    gate_req_t        head, hold_q;
    logic             fifo_full, fifo_empty, pop;
    logic             deny_chk, grant, deny, win_wrap;

    logic             m_sel_q, m_sel_d;
    logic [31:0]      m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic             deny_pulse_q, deny_pulse_d;
    logic [15:0]      deny_cnt_q, deny_cnt_d;
    logic [7:0]       grant_cnt_q, grant_cnt_d;
    logic [WIN_W-1:0] win_q, win_d;

    boreal_sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (req_valid),
        .wdata_i ({req_idx, req_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign req_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);

    // Config is only consulted here, while the FSM sits in CHECK.
    assign deny_chk = !cfg_arm || (hold_q.idx >= cfg_idx_limit) || (grant_cnt_q == RMAX);
    assign win_wrap = (win_q == WIN_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_CHECK;
            ST_CHECK: state_d = deny_chk ? ST_IDLE : ST_WRITE;
            ST_WRITE: if (m_ack) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        pop          = (state_q == ST_IDLE) && !fifo_empty;
        grant        = (state_q == ST_CHECK) && !deny_chk;
        deny         = (state_q == ST_CHECK) && deny_chk;
        m_sel_d      = m_sel_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        deny_pulse_d = deny;
        deny_cnt_d   = deny_cnt_q;
        win_d        = win_wrap ? '0 : win_q + 1'b1;
        // A grant on the wrap edge is charged to the new window.
        grant_cnt_d  = (win_wrap ? 8'd0 : grant_cnt_q) + {7'd0, grant};

        if (grant) begin
            m_sel_d   = 1'b1;
            m_addr_d  = idx_to_addr(hold_q.idx);
            m_wdata_d = hold_q.data;
        end else if ((state_q == ST_WRITE) && m_ack) begin
            m_sel_d   = 1'b0;
        end

        if (deny && (deny_cnt_q != 16'hFFFF)) deny_cnt_d = deny_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sel_q      <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            deny_pulse_q <= 1'b0;
            deny_cnt_q   <= '0;
            grant_cnt_q  <= '0;
            win_q        <= '0;
        end else begin
            m_sel_q      <= m_sel_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            deny_pulse_q <= deny_pulse_d;
            deny_cnt_q   <= deny_cnt_d;
            grant_cnt_q  <= grant_cnt_d;
            win_q        <= win_d;
        end
    end

    // Holding register is pure data; it is only read in CHECK after a pop.
    always_ff @(posedge clk) begin
        if (pop) hold_q <= head;
    end

    assign m_sel      = m_sel_q;
    assign m_wr       = m_sel_q;
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;
    assign deny_pulse = deny_pulse_q;
    assign deny_count = deny_cnt_q;

endmodule

// File: tb/tb_boreal_action_gate.sv
module tb_boreal_action_gate;

    localparam int DEPTH = 4;
    localparam int RW    = 64;
    localparam int RMAX  = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_idx;
    logic [31:0] req_data;
    logic        cfg_arm;
    logic [7:0]  cfg_idx_limit;
    logic        m_sel;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic        deny_pulse;
    logic [15:0] deny_count;
    logic        busy;
    logic        ack_en;

    assign m_ack = ack_en & m_sel;

    boreal_action_gate #(
        .FIFO_DEPTH  (DEPTH),
        .RATE_WINDOW (RW),
        .RATE_MAX    (RMAX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_idx       (req_idx),
        .req_data      (req_data),
        .cfg_arm       (cfg_arm),
        .cfg_idx_limit (cfg_idx_limit),
        .m_sel         (m_sel),
        .m_wr          (m_wr),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_ack         (m_ack),
        .deny_pulse    (deny_pulse),
        .deny_count    (deny_count),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  idx;
        logic [31:0] data;
        logic        arm;
        logic [7:0]  limit;
    } sb_t;

    sb_t sb[$];
    int  n_checks;
    int  n_err;
    int  win;
    int  gcnt;
    int  n_writes;
    int  n_denies;
    bit  prev_sel;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: window/budget tracker plus in-order outcome scoreboard.
    task automatic monitor_step();
        sb_t e;
        bit  g_obs, d_obs, g_exp;
        if (!rst_n) begin
            sb.delete();
            win      = 0;
            gcnt     = 0;
            prev_sel = 1'b0;
            n_writes = 0;
            n_denies = 0;
            return;
        end
        check_eq("wr_eq_sel", 32'(m_wr), 32'(m_sel));
        g_obs = m_sel && !prev_sel;
        d_obs = deny_pulse;
        g_exp = 1'b0;
        if (g_obs || d_obs) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_outcome", {30'd0, g_obs, d_obs}, 32'd0);
            end else begin
                e = sb.pop_front();
                g_exp = e.arm && (e.idx < e.limit) && (gcnt != RMAX);
                check_eq("grant", 32'(g_obs), 32'(g_exp));
                if (g_obs) begin
                    check_eq("m_addr", m_addr, {22'd0, e.idx, 2'b00});
                    check_eq("m_wdata", m_wdata, e.data);
                end
            end
            if (g_obs) n_writes++;
            if (d_obs) n_denies++;
        end
        if (win == RW - 1) begin
            win  = 0;
            gcnt = g_exp ? 1 : 0;
        end else begin
            win  = win + 1;
            gcnt = gcnt + (g_exp ? 1 : 0);
        end
        prev_sel = m_sel;
    endtask

    task automatic try_send(input logic [7:0] idx, input logic [31:0] data, output bit acc);
        @(negedge clk);
        if (req_ready) begin
            req_valid = 1'b1;
            req_idx   = idx;
            req_data  = data;
            sb.push_back('{idx, data, cfg_arm, cfg_idx_limit});
            @(posedge clk);
            #1 req_valid = 1'b0;
            acc = 1'b1;
        end else begin
            acc = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] idx, input logic [31:0] data);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            try_send(idx, data, ok);
            n++;
        end
        check_eq("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!busy && !m_sel && sb.size() == 0) break;
        end
        check_eq("drained_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_sel();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (m_sel) break;
        end
        check_eq("sel_seen", 32'(m_sel), 32'd1);
    endtask

    task automatic wait_win(input int target);
        for (int n = 0; n < 3 * RW; n++) begin
            @(negedge clk);
            if (win == target) break;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic run_tests();
        bit acc;
        int accepts;

        // Reset state
        do_reset();
        #1;
        check_eq("rst_m_sel", 32'(m_sel), 32'd0);
        check_eq("rst_m_wr", 32'(m_wr), 32'd0);
        check_eq("rst_m_addr", m_addr, 32'd0);
        check_eq("rst_m_wdata", m_wdata, 32'd0);
        check_eq("rst_deny_pulse", 32'(deny_pulse), 32'd0);
        check_eq("rst_deny_count", 32'(deny_count), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);

        // Write acceptance and latency
        cfg_arm = 1'b1; cfg_idx_limit = 8'd8; ack_en = 1'b1;
        send(8'd2, 32'hA5A5_0001);
        @(negedge clk); check_eq("lat_e0_sel", 32'(m_sel), 32'd0);
        @(negedge clk); check_eq("lat_e1_sel", 32'(m_sel), 32'd0);
        @(negedge clk);
        check_eq("lat_e2_sel", 32'(m_sel), 32'd1);
        check_eq("lat_e2_wr", 32'(m_wr), 32'd1);
        check_eq("lat_e2_addr", m_addr, 32'h0000_0008);
        check_eq("lat_e2_wdata", m_wdata, 32'hA5A5_0001);
        @(negedge clk); check_eq("single_cycle_sel", 32'(m_sel), 32'd0);
        drain();
        check_eq("t1_writes", n_writes, 32'd1);
        check_eq("t1_denies", n_denies, 32'd0);
        check_eq("t1_deny_count", 32'(deny_count), 32'd0);

        // Index limit
        do_reset();
        cfg_arm = 1'b1; cfg_idx_limit = 8'd4;
        send(8'd4, 32'h1111_0004);
        drain();
        check_eq("lim_writes", n_writes, 32'd0);
        check_eq("lim_denies", n_denies, 32'd1);
        check_eq("lim_deny_count", 32'(deny_count), 32'd1);
        send(8'd3, 32'h1111_0003);
        drain();
        check_eq("lim_ok_writes", n_writes, 32'd1);
        check_eq("lim_ok_deny_count", 32'(deny_count), 32'd1);

        // Disarmed gate
        do_reset();
        cfg_arm = 1'b0; cfg_idx_limit = 8'd8;
        for (int i = 0; i < 3; i++) send(8'(i), 32'h2222_0000 + 32'(i));
        drain();
        check_eq("dis_writes", n_writes, 32'd0);
        check_eq("dis_denies", n_denies, 32'd3);
        check_eq("dis_deny_count", 32'(deny_count), 32'd3);
        check_eq("dis_busy", 32'(busy), 32'd0);

        // Rate limit: 6 in one window, then one more after the wrap
        do_reset();
        cfg_arm = 1'b1; cfg_idx_limit = 8'd8;
        for (int i = 0; i < 6; i++) send(8'(i), 32'hB000_0000 + 32'(i));
        drain();
        check_eq("rate_writes", n_writes, 32'd4);
        check_eq("rate_denies", n_denies, 32'd2);
        check_eq("rate_deny_count", 32'(deny_count), 32'd2);
        wait_win(RW - 1);
        @(negedge clk);
        send(8'd7, 32'hB000_0007);
        drain();
        check_eq("rate_wrap_writes", n_writes, 32'd5);
        check_eq("rate_wrap_deny_count", 32'(deny_count), 32'd2);

        // Backpressure with a stalled slave; stall spans a window wrap
        do_reset();
        cfg_arm = 1'b1; cfg_idx_limit = 8'd8; ack_en = 1'b0;
        wait_win(45);
        send(8'd1, 32'hC000_0001);
        wait_sel();
        accepts = 0;
        for (int k = 0; k < 8; k++) begin
            try_send(8'(2 + k), 32'hC000_0002 + 32'(k), acc);
            if (!acc) break;
            accepts++;
        end
        check_eq("bp_accepts", accepts, DEPTH);
        check_eq("bp_ready_low", 32'(req_ready), 32'd0);
        repeat (20) @(negedge clk);
        check_eq("bp_stall_sel", 32'(m_sel), 32'd1);
        ack_en = 1'b1;
        drain();
        check_eq("bp_writes", n_writes, 32'(DEPTH + 1));
        check_eq("bp_denies", n_denies, 32'd0);

        // Reset in the middle of a write
        do_reset();
        cfg_arm = 1'b1; cfg_idx_limit = 8'd8; ack_en = 1'b0;
        send(8'd5, 32'hD000_0005);
        wait_sel();
        send(8'd6, 32'hD000_0006);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_sel", 32'(m_sel), 32'd0);
        check_eq("mid_rst_wr", 32'(m_wr), 32'd0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
        check_eq("mid_rst_deny_count", 32'(deny_count), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        ack_en = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("post_rst_writes", n_writes, 32'd0);
        check_eq("post_rst_sel", 32'(m_sel), 32'd0);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_err         = 0;
        win           = 0;
        gcnt          = 0;
        n_writes      = 0;
        n_denies      = 0;
        prev_sel      = 1'b0;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_idx       = 8'd0;
        req_data      = 32'd0;
        cfg_arm       = 1'b0;
        cfg_idx_limit = 8'd0;
        ack_en        = 1'b1;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            begin
                run_tests();
                $display("Result: errors=%0d of %0d checks", n_err, n_checks);
                $finish;
            end
        join
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/boreal_action_gate.md
Name: boreal_action_gate

Overview:
- Upstream stage of the privileged I/O register bank. It is the single Gate master port that writes that bank.
- Buffers AI action requests, i.e. (register index, value) pairs, in a small FIFO.
- Checks each request against an arm bit, an index limit and a per-window rate budget.
- Issues each approved request as a single bus write. Denied requests are dropped, pulsed and counted.

Parameters:
- FIFO_DEPTH, 4: request FIFO entries; power of 2, ≥2.
- RATE_WINDOW, 1024: rate window length in clk cycles; ≥2.
- RATE_MAX, 16: maximum granted writes per window; 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  action request valid
- req_ready  out  1  FIFO not full
- req_idx  in  8  target register index
- req_data  in  32  value to write
- cfg_arm  in  1  gate enabled; 0 denies every request
- cfg_idx_limit  in  8  indices ≥ this value are denied (0 denies all)
- m_sel  out  1  bus select to I/O bank
- m_wr  out  1  bus write strobe
- m_addr  out  32  byte address = {22'b0, idx, 2'b00}
- m_wdata  out  32  write data
- m_ack  in  1  slave acknowledge
- deny_pulse  out  1  one-cycle pulse per denied request
- deny_count  out  16  saturating denied-request counter
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset values: all outputs 0 except req_ready=1. FIFO empty, FSM IDLE, window counter 0, grant counter 0.
- Async reset mid-write drops m_sel/m_wr at once and loses all queued requests.
- Input handshake:
  - A request is accepted on a posedge with req_valid && req_ready.
  - req_ready = !full, registered-equivalent; it has no combinational path from req_valid.
  - Push and pop in the same cycle while full is not allowed. req_ready is already 0 when full, so this cannot occur.
  - Push and pop in the same cycle while non-full keeps the occupancy unchanged.
- FSM:
  - IDLE → CHECK when the FIFO is non-empty. The head is popped into a holding register on that edge.
  - CHECK (1 cycle), denied → IDLE. deny_pulse=1 in the following cycle; deny_count+1, saturating at 16'hFFFF. A request is denied if any of these holds:
    - !cfg_arm
    - idx ≥ cfg_idx_limit
    - grant counter == RATE_MAX
  - CHECK, granted → WRITE. The grant counter increments on this edge.
  - WRITE: m_sel=m_wr=1, m_addr and m_wdata from the holding register, all registered.
    - Holds until m_ack=1, then → IDLE with m_sel/m_wr cleared on the same edge.
    - No timeout.
    - cfg_arm changes during WRITE do not abort the write.
- Latency: request accepted at edge 0 → CHECK after edge 1 → m_sel high from edge 2. With a combinational-ack slave, one write completes every 3 cycles.
- Rate window:
  - The free-running window counter runs 0..RATE_WINDOW-1 and wraps.
  - On wrap the grant counter clears.
  - If a grant occurs on the same edge as the wrap, the grant counter becomes 1, i.e. the grant is charged to the new window.
- Config inputs are sampled only in CHECK.
- m_addr upper bits are always 0. m_wr is never 1 without m_sel.

Decomposition:
- Shared package boreal_gate_pkg holds:
  - FSM state encoding: IDLE=2'd0, CHECK=2'd1, WRITE=2'd2.
  - Address formation constant (index shift 2).
  - Default RATE_WINDOW and RATE_MAX.
- One sub-module: boreal_sync_fifo. It is a synchronous FIFO parameterised by width (40) and depth, with full/empty outputs and no registered read latency (head visible combinationally).

Test Plan:
- Write acceptance: cfg_arm=1, limit=8, request idx=2 data=32'hA5A5_0001. Expect m_addr=32'h8 and m_wdata=32'hA5A5_0001 with m_sel=m_wr=1 starting 2 cycles after accept, a single cycle with ack tied to sel, and no deny_pulse.
- Index limit: limit=4, request idx=4. Expect no m_sel, deny_pulse once, deny_count=1. Then idx=3 is granted.
- Disarmed gate: cfg_arm=0, send 3 requests. Expect 3 deny pulses, deny_count=3, no bus activity, busy low after drain.
- Rate limit with RATE_WINDOW=64, RATE_MAX=4: burst 6 valid requests. Expect 4 writes and 2 denials. After the window wraps, a 7th request is granted.
- Backpressure and stall with m_ack held 0 for 20 cycles: push until req_ready=0, which happens after FIFO_DEPTH accepts. Release ack and expect all entries written in order with no loss.
- Reset mid-WRITE: assert rst_n=0 while m_sel=1. Expect m_sel=0 immediately, req_ready=1, deny_count=0, and no write after release.
